// File: rtl/key_debounce_pkg.sv
// Shared types, defaults and sizing helper for the key_debounce input stage.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  localparam bit INV_BTN_DEF         = 1'b0;
  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int LONG_CYCLES_DEF     = 64;
  localparam bit RUN_EN_INIT_DEF     = 1'b1;

  // Bits needed to hold values 0..n, never less than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Button-side bundle: raw key in, conditioned level/pulses/enable out, plus FSM state for observation.
// Handshake: none; key_i is a free-running asynchronous level, every output is a registered level or one-cycle strobe.
interface key_debounce_if;
  import key_pkg::*;

  logic       key_i;
  logic       key_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic       run_en;
  key_state_t state;

  modport master (
    output key_i,
    input  key_level, press_pulse, release_pulse, long_pulse, run_en, state
  );

  modport slave (
    input  key_i,
    output key_level, press_pulse, release_pulse, long_pulse, run_en, state
  );
endinterface

// File: rtl/key_debounce_sync.sv
// Polarity normalisation and two-flop synchroniser for the raw button pin.
module key_sync #(
  parameter bit INV_BTN = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic s
);
  logic ff1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ff1 <= 1'b0;
      s   <= 1'b0;
    end else begin
      ff1 <= key ^ INV_BTN;
      s   <= ff1;
    end
  end
endmodule

// File: rtl/key_debounce.sv
// Debounces a synchronised push-button, emits press/release/long-press strobes and a run_en toggle level.
module key_debounce
  import key_pkg::*;
#(
  parameter bit INV_BTN         = INV_BTN_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
  parameter bit RUN_EN_INIT     = RUN_EN_INIT_DEF
) (
  input logic           clk,
  input logic           rst_n,
  key_debounce_if.slave bus
);
  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int HW = cnt_width(LONG_CYCLES);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  logic s;

  key_sync #(.INV_BTN(INV_BTN)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (bus.key_i),
    .s     (s)
  );

  key_state_t    state, state_d;
  logic [DW-1:0] deb_cnt, deb_d;
  logic [HW-1:0] hold_cnt, hold_d;
  logic          long_flag, flag_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          long_q, long_d;
  logic          run_q, run_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      deb_cnt   <= '0;
      hold_cnt  <= '0;
      long_flag <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      rel_q     <= 1'b0;
      long_q    <= 1'b0;
      run_q     <= RUN_EN_INIT;
    end else begin
      state     <= state_d;
      deb_cnt   <= deb_d;
      hold_cnt  <= hold_d;
      long_flag <= flag_d;
      level_q   <= level_d;
      press_q   <= press_d;
      rel_q     <= rel_d;
      long_q    <= long_d;
      run_q     <= run_d;
    end
  end

  always_comb begin
    state_d = state;
    deb_d   = deb_cnt;
    hold_d  = hold_cnt;
    flag_d  = long_flag;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    run_d   = run_q;
    case (state)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          deb_d   = DW'(1);
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          deb_d   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_d = PRESSED;
          level_d = 1'b1;
          press_d = 1'b1;
          hold_d  = '0;
          flag_d  = 1'b0;
        end else begin
          deb_d = deb_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          deb_d   = DW'(1);
        end else if (LONG_CYCLES != 0 && !long_flag) begin
          // long_flag stops the count, so hold_cnt tops out at LONG_CYCLES.
          hold_d = hold_cnt + 1'b1;
          if (hold_cnt == HOLD_LAST) begin
            long_d = 1'b1;
            flag_d = 1'b1;
          end
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = PRESSED;
          deb_d   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
          rel_d   = 1'b1;
          if (!long_flag) run_d = ~run_q;
        end else begin
          deb_d = deb_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.key_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = rel_q;
  assign bus.long_pulse    = long_q;
  assign bus.run_en        = run_q;
  assign bus.state         = state;
endmodule

// File: tb/tb_key_debounce.sv
// Directed bench: an INV_BTN=0 and an INV_BTN=1 instance see mirrored key stimulus and must both match the same expectation.
module tb_key_debounce;
  import key_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic exp_run;
  logic [4:0] exp_v;
  logic [4:0] obs_a;
  logic [4:0] obs_b;

  key_debounce_if bus_a ();
  key_debounce_if bus_b ();

  key_debounce #(.INV_BTN(1'b0), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(10), .RUN_EN_INIT(1'b1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  key_debounce #(.INV_BTN(1'b1), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(10), .RUN_EN_INIT(1'b1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  // Observed vector order: {key_level, press_pulse, release_pulse, long_pulse, run_en}.
  assign obs_a = {bus_a.key_level, bus_a.press_pulse, bus_a.release_pulse, bus_a.long_pulse, bus_a.run_en};
  assign obs_b = {bus_b.key_level, bus_b.press_pulse, bus_b.release_pulse, bus_b.long_pulse, bus_b.run_en};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_key(input logic v);
    bus_a.key_i = v;
    bus_b.key_i = ~v;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    set_key(1'b0);
    repeat (3) tick();
    exp_run = 1'b1;
    exp_v = {4'b0000, exp_run};
    total++;
    if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
      bad++;
      $display("FAIL reset_outputs a=%b b=%b want=%b", obs_a, obs_b, exp_v);
    end
    total++;
    if ({bus_a.state, bus_b.state} !== {IDLE, IDLE}) begin
      bad++;
      $display("FAIL reset_state a=%0d b=%0d want=%0d", bus_a.state, bus_b.state, IDLE);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      total++;
      if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
        bad++;
        $display("FAIL idle_quiet edge=%0d a=%b b=%b want=%b", i, obs_a, obs_b, exp_v);
      end
    end
  endtask

  task automatic test_clean_press();
    set_key(1'b1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_v = {(i >= 6), (i == 6), 1'b0, 1'b0, exp_run};
      total++;
      if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
        bad++;
        $display("FAIL clean_press edge=%0d a=%b b=%b want=%b", i, obs_a, obs_b, exp_v);
      end
    end
    set_key(1'b0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 6) exp_run = ~exp_run;
      exp_v = {(i < 6), 1'b0, (i == 6), 1'b0, exp_run};
      total++;
      if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
        bad++;
        $display("FAIL clean_release edge=%0d a=%b b=%b want=%b", i, obs_a, obs_b, exp_v);
      end
    end
  endtask

  task automatic test_bounce();
    for (int j = 0; j < 4; j++) begin
      set_key((j % 2) == 0);
      tick();
      exp_v = {4'b0000, exp_run};
      total++;
      if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
        bad++;
        $display("FAIL bounce_quiet step=%0d a=%b b=%b want=%b", j, obs_a, obs_b, exp_v);
      end
    end
    set_key(1'b1);
    for (int i = 1; i <= 6; i++) begin
      tick();
      exp_v = {(i >= 6), (i == 6), 1'b0, 1'b0, exp_run};
      total++;
      if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
        bad++;
        $display("FAIL bounce_press edge=%0d a=%b b=%b want=%b", i, obs_a, obs_b, exp_v);
      end
    end
  endtask

  // Continues from the committed press left by test_bounce.
  task automatic test_long();
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_v = {1'b1, 1'b0, 1'b0, (i == 10), exp_run};
      total++;
      if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
        bad++;
        $display("FAIL long_hold edge=%0d a=%b b=%b want=%b", i, obs_a, obs_b, exp_v);
      end
    end
    set_key(1'b0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_v = {(i < 6), 1'b0, (i == 6), 1'b0, exp_run};
      total++;
      if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
        bad++;
        $display("FAIL long_release edge=%0d a=%b b=%b want=%b", i, obs_a, obs_b, exp_v);
      end
    end
  endtask

  // Edges counted from the press commit. The 2-cycle glitch keeps the FSM out of
  // PRESSED for three edges (enter RELEASE_WAIT, one count, return), so the hold
  // counter reaches its terminal value three edges late: long_pulse at edge 13.
  task automatic test_glitch();
    set_key(1'b1);
    for (int i = 1; i <= 6; i++) begin
      tick();
      exp_v = {(i >= 6), (i == 6), 1'b0, 1'b0, exp_run};
      total++;
      if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
        bad++;
        $display("FAIL glitch_press edge=%0d a=%b b=%b want=%b", i, obs_a, obs_b, exp_v);
      end
    end
    for (int e = 1; e <= 16; e++) begin
      if (e == 4) set_key(1'b0);
      if (e == 6) set_key(1'b1);
      tick();
      exp_v = {1'b1, 1'b0, 1'b0, (e == 13), exp_run};
      total++;
      if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
        bad++;
        $display("FAIL glitch_hold edge=%0d a=%b b=%b want=%b", e, obs_a, obs_b, exp_v);
      end
    end
    set_key(1'b0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_v = {(i < 6), 1'b0, (i == 6), 1'b0, exp_run};
      total++;
      if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
        bad++;
        $display("FAIL glitch_release edge=%0d a=%b b=%b want=%b", i, obs_a, obs_b, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_press();
    set_key(1'b1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      exp_v = {4'b0000, exp_run};
      total++;
      if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
        bad++;
        $display("FAIL midrst_wait edge=%0d a=%b b=%b want=%b", i, obs_a, obs_b, exp_v);
      end
    end
    rst_n = 1'b0;
    tick();
    exp_run = 1'b1;
    exp_v = {4'b0000, exp_run};
    total++;
    if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
      bad++;
      $display("FAIL midrst_outputs a=%b b=%b want=%b", obs_a, obs_b, exp_v);
    end
    total++;
    if ({bus_a.state, bus_b.state} !== {IDLE, IDLE}) begin
      bad++;
      $display("FAIL midrst_state a=%0d b=%0d want=%0d", bus_a.state, bus_b.state, IDLE);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      exp_v = {(i >= 6), (i == 6), 1'b0, 1'b0, exp_run};
      total++;
      if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
        bad++;
        $display("FAIL midrst_repress edge=%0d a=%b b=%b want=%b", i, obs_a, obs_b, exp_v);
      end
    end
    set_key(1'b0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 6) exp_run = ~exp_run;
      exp_v = {(i < 6), 1'b0, (i == 6), 1'b0, exp_run};
      total++;
      if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
        bad++;
        $display("FAIL midrst_release edge=%0d a=%b b=%b want=%b", i, obs_a, obs_b, exp_v);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total   = 0;
    bad     = 0;
    exp_run = 1'b1;
    rst_n   = 1'b0;
    set_key(1'b0);
    test_reset();
    test_clean_press();
    test_bounce();
    test_long();
    test_glitch();
    test_reset_mid_press();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
